alu_multicycle: RTL and testbench

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_iter_muldiv.sv | 116 +++++++++++
 rtl/alu_multicycle.sv | 175 +++++++++++++++++
 tb/tb_alu_multicycle.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the multicycle ALU: opcodes, FSM state encoding and
// the width of the iteration counter used by the mul/div datapath.
package alu_pkg;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;
  localparam logic [4:0] OP_MUL = 5'd6;
  localparam logic [4:0] OP_DIV = 5'd7;

  typedef logic [1:0] alu_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Wide enough to count WIDTH iterations for the largest legal WIDTH (64).
  localparam int ITER_CNT_W = 7;

  // Two's-complement overflow of s = a + b, judged from the sign bits only.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                   input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative signed multiply (radix-2 Booth) / divide (non-restoring on
// magnitudes), one iteration per clock, WIDTH iterations per operation.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             last,
  output logic [WIDTH-1:0] result,
  output logic             exception
);

  logic                  busy_q, busy_d;
  logic [ITER_CNT_W-1:0] cnt_q, cnt_d;
  logic                  div_q, div_d;
  logic                  neg_q, neg_d;
  logic                  dovf_q, dovf_d;
  logic                  qm1_q, qm1_d;
  logic [WIDTH+1:0]      hi_q, hi_d;
  logic [WIDTH-1:0]      lo_q, lo_d;
  logic [WIDTH-1:0]      m_q, m_d;

  logic [WIDTH+1:0]      m_ext;
  logic [WIDTH+1:0]      shifted;
  logic [WIDTH+1:0]      sum;
  logic [WIDTH-1:0]      abs_a, abs_b;

  always_comb begin
    abs_a   = op_a[WIDTH-1] ? -op_a : op_a;
    abs_b   = op_b[WIDTH-1] ? -op_b : op_b;
    // Divisor is an unsigned magnitude; multiplicand is signed.
    m_ext   = div_q ? {2'b00, m_q} : {{2{m_q[WIDTH-1]}}, m_q};
    shifted = {hi_q[WIDTH:0], lo_q[WIDTH-1]};
    sum     = hi_q;
    last    = busy_q && (cnt_q == ITER_CNT_W'(WIDTH - 1));

    busy_d = busy_q;
    cnt_d  = cnt_q;
    div_d  = div_q;
    neg_d  = neg_q;
    dovf_d = dovf_q;
    qm1_d  = qm1_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    m_d    = m_q;

    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      div_d  = is_div;
      hi_d   = '0;
      qm1_d  = 1'b0;
      if (is_div) begin
        lo_d   = abs_a;
        m_d    = abs_b;
        neg_d  = op_a[WIDTH-1] ^ op_b[WIDTH-1];
        dovf_d = (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&op_b);
      end else begin
        lo_d   = op_a;
        m_d    = op_b;
        neg_d  = 1'b0;
        dovf_d = 1'b0;
      end
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
      if (last) begin
        busy_d = 1'b0;
      end
      if (div_q) begin
        sum  = hi_q[WIDTH+1] ? (shifted + m_ext) : (shifted - m_ext);
        hi_d = sum;
        lo_d = {lo_q[WIDTH-2:0], ~sum[WIDTH+1]};
      end else begin
        case ({lo_q[0], qm1_q})
          2'b01:   sum = hi_q + m_ext;
          2'b10:   sum = hi_q - m_ext;
          default: sum = hi_q;
        endcase
        hi_d  = {sum[WIDTH+1], sum[WIDTH+1:1]};
        lo_d  = {sum[0], lo_q[WIDTH-1:1]};
        qm1_d = lo_q[0];
      end
    end

    // Product sits in {hi_q[WIDTH-1:0], lo_q}; quotient magnitude in lo_q.
    result    = div_q ? (neg_q ? -lo_q : lo_q) : lo_q;
    exception = div_q ? dovf_q : (hi_q[WIDTH-1:0] != {WIDTH{lo_q[WIDTH-1]}});
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    div_q  <= div_d;
    neg_q  <= neg_d;
    dovf_q <= dovf_d;
    qm1_q  <= qm1_d;
    hi_q   <= hi_d;
    lo_q   <= lo_d;
    m_q    <= m_d;
  end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU with valid/ready handshakes. Define ALU_MULDIV_EN to build in
// the iterative signed mul/div; otherwise opcodes 6 and 7 are illegal.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [WIDTH-1:0]   data_operandB,
  input  logic [4:0]         ctrl_ALUopcode,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_result,
  output logic               data_exception,
  output logic               isNotEqual,
  output logic               isLessThan
);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             ne_q, ne_d;
  logic             lt_q, lt_d;

  logic [WIDTH-1:0] sum, diff;
  logic             add_v, sub_v;
  logic [WIDTH-1:0] alu_res;
  logic             alu_exc;

`ifdef ALU_MULDIV_EN
  logic             go_busy;
  logic             use_iter_q, use_iter_d;
  logic             iter_start;
  logic             iter_last;
  logic [WIDTH-1:0] iter_result;
  logic             iter_exc;
`endif

  always_comb begin
    sum     = data_operandA + data_operandB;
    diff    = data_operandA - data_operandB;
    add_v   = add_ovf(data_operandA[WIDTH-1], data_operandB[WIDTH-1], sum[WIDTH-1]);
    sub_v   = add_ovf(data_operandA[WIDTH-1], ~data_operandB[WIDTH-1], diff[WIDTH-1]);
    alu_res = '0;
    alu_exc = 1'b0;
`ifdef ALU_MULDIV_EN
    go_busy = 1'b0;
`endif
    case (ctrl_ALUopcode)
      OP_ADD: begin
        alu_res = sum;
        alu_exc = add_v;
      end
      OP_SUB: begin
        alu_res = diff;
        alu_exc = sub_v;
      end
      OP_AND: alu_res = data_operandA & data_operandB;
      OP_OR:  alu_res = data_operandA | data_operandB;
      OP_SLL: alu_res = data_operandA << ctrl_shiftamt;
      OP_SRA: alu_res = $signed(data_operandA) >>> ctrl_shiftamt;
`ifdef ALU_MULDIV_EN
      OP_MUL: go_busy = 1'b1;
      OP_DIV: begin
        // Divide-by-zero completes immediately with result 0.
        if (data_operandB == '0) begin
          alu_exc = 1'b1;
        end else begin
          go_busy = 1'b1;
        end
      end
`endif
      default: alu_exc = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    exc_d    = exc_q;
    ne_d     = ne_q;
    lt_d     = lt_q;
`ifdef ALU_MULDIV_EN
    use_iter_d = use_iter_q;
    iter_start = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          result_d = alu_res;
          exc_d    = alu_exc;
          ne_d     = (data_operandA != data_operandB);
          lt_d     = diff[WIDTH-1] ^ sub_v;
`ifdef ALU_MULDIV_EN
          use_iter_d = go_busy;
          iter_start = go_busy;
          state_d    = go_busy ? ST_BUSY : ST_DONE;
`else
          state_d  = ST_DONE;
`endif
        end
      end
`ifdef ALU_MULDIV_EN
      ST_BUSY: begin
        if (iter_last) begin
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      exc_q    <= 1'b0;
      ne_q     <= 1'b0;
      lt_q     <= 1'b0;
`ifdef ALU_MULDIV_EN
      use_iter_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      ne_q     <= ne_d;
      lt_q     <= lt_d;
`ifdef ALU_MULDIV_EN
      use_iter_q <= use_iter_d;
`endif
    end
  end

`ifdef ALU_MULDIV_EN
  alu_iter_muldiv #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clock    (clock),
    .reset    (reset),
    .start    (iter_start),
    .is_div   (ctrl_ALUopcode == OP_DIV),
    .op_a     (data_operandA),
    .op_b     (data_operandB),
    .last     (iter_last),
    .result   (iter_result),
    .exception(iter_exc)
  );

  // The iterator holds its registers once idle, so its output stays stable in DONE.
  assign data_result    = use_iter_q ? iter_result : result_q;
  assign data_exception = use_iter_q ? iter_exc : exc_q;
`else
  assign data_result    = result_q;
  assign data_exception = exc_q;
`endif

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign isNotEqual = ne_q;
  assign isLessThan = lt_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed and randomized checks of alu_multicycle (WIDTH=32) against a
// plain-arithmetic reference model; follows ALU_MULDIV_EN if defined.
module tb_alu_multicycle;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  op = '0;
  logic [4:0]  sh = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] data_result;
  logic        data_exception;
  logic        isNotEqual;
  logic        isLessThan;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  alu_multicycle #(.WIDTH(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .data_operandA (a),
    .data_operandB (b),
    .ctrl_ALUopcode(op),
    .ctrl_shiftamt (sh),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .data_result   (data_result),
    .data_exception(data_exception),
    .isNotEqual    (isNotEqual),
    .isLessThan    (isLessThan)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: signed arithmetic on 64-bit integers.
  function automatic void model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic [4:0] s, output logic [31:0] r, output logic e,
                                output int lat);
    longint sx, sy, t, sr;
    int     ix, iy;
    ix  = $signed(x);
    iy  = $signed(y);
    sx  = ix;
    sy  = iy;
    r   = '0;
    e   = 1'b0;
    lat = 1;
    case (o)
      5'd0: begin
        t = sx + sy; r = t[31:0]; ix = $signed(r); sr = ix; e = (t != sr);
      end
      5'd1: begin
        t = sx - sy; r = t[31:0]; ix = $signed(r); sr = ix; e = (t != sr);
      end
      5'd2: r = x & y;
      5'd3: r = x | y;
      5'd4: r = x << s;
      5'd5: r = $signed(x) >>> s;
`ifdef ALU_MULDIV_EN
      5'd6: begin
        t = sx * sy; r = t[31:0]; ix = $signed(r); sr = ix; e = (t != sr); lat = 33;
      end
      5'd7: begin
        if (y == 32'd0) begin
          r = '0; e = 1'b1;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          r = 32'h8000_0000; e = 1'b1; lat = 33;
        end else begin
          t = sx / sy; r = t[31:0]; lat = 33;
        end
      end
`endif
      default: begin
        r = '0; e = 1'b1;
      end
    endcase
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    chk("in_ready_wait", in_ready, 1'b1);
  endtask

  // Issues one op, measures latency, checks outputs; consumes unless hold=1.
  task automatic run_op(input string tag, input logic [4:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] s, input bit hold);
    logic [31:0] er;
    logic        ee;
    int          el;
    int          lat;
    logic        lt_exp;
    model(o, x, y, s, er, ee, el);
    lt_exp = ($signed(x) < $signed(y));
    wait_ready();
    op = o; a = x; b = y; sh = s; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_res"}, data_result, er);
    chk({tag, "_exc"}, data_exception, ee);
    chk({tag, "_ne"}, isNotEqual, (x != y));
    chk({tag, "_lt"}, isLessThan, lt_exp);
    if (!hold) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    logic [31:0] x, y;
    logic [4:0]  o;
    int          r;

    // Reset state.
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", data_result, 32'd0);
    chk("rst_exc", data_exception, 1'b0);
    chk("rst_ne", isNotEqual, 1'b0);
    chk("rst_lt", isLessThan, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    // Directed corner cases.
    run_op("add_ovf", 5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 1'b0);
    run_op("add_ovf_lit", 5'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 1'b1);
    chk("add_ovf_lit_res", data_result, 32'h8000_0000);
    chk("add_ovf_lit_exc", data_exception, 1'b1);
    @(posedge clock); #1;
    run_op("mul_neg", 5'd6, 32'hFFFF_FFFD, 32'd7, 5'd0, 1'b0);
    run_op("mul_ovf", 5'd6, 32'h0001_0000, 32'h0001_0000, 5'd0, 1'b0);
    run_op("mul_min", 5'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0);
    run_op("div_neg", 5'd7, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b0);
    run_op("div_zero", 5'd7, 32'd7, 32'd0, 5'd0, 1'b0);
    run_op("div_min", 5'd7, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 1'b0);
    run_op("div_bymin", 5'd7, 32'h8000_0000, 32'h8000_0000, 5'd0, 1'b0);
    run_op("sub_ovf", 5'd1, 32'h8000_0000, 32'h0000_0001, 5'd0, 1'b0);
    run_op("sll31", 5'd4, 32'h0000_0003, 32'd0, 5'd31, 1'b0);
    run_op("sra31", 5'd5, 32'h8000_0000, 32'd0, 5'd31, 1'b0);
    run_op("sra_pos", 5'd5, 32'h7000_0000, 32'd5, 5'd17, 1'b0);
    run_op("illegal", 5'd31, 32'h1234_5678, 32'h1234_5678, 5'd3, 1'b0);

    // Back-pressure: result held, inputs ignored while out_ready=0.
    out_ready = 1'b0;
    run_op("stall", 5'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 1'b1);
    held = data_result;
    for (int i = 0; i < 5; i++) begin
      op = 5'd0; a = $urandom; b = $urandom; in_valid = 1'b1;
      @(posedge clock); #1;
      chk("stall_res", data_result, held);
      chk("stall_in_ready", in_ready, 1'b0);
      chk("stall_out_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    chk("stall_release_ov", out_valid, 1'b0);
    chk("stall_release_ir", in_ready, 1'b1);
    @(posedge clock); #1;
    chk("stall_no_queue", out_valid, 1'b0);

    // Reset in the middle of a multiply.
    op = 5'd6; a = 32'h1234_5678; b = 32'h0000_0321; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_result", data_result, 32'd0);
    chk("abort_exc", data_exception, 1'b0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    chk("abort_in_ready", in_ready, 1'b1);
    run_op("post_abort_add", 5'd0, 32'd100, 32'hFFFF_FFF6, 5'd0, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 11);
      o = (r < 9) ? 5'(r) : 5'($urandom_range(8, 31));
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 3) == 0) x = 32'($signed(16'($urandom)));
      if ($urandom_range(0, 3) == 0) y = 32'($signed(12'($urandom)));
      r = $urandom_range(0, 9);
      if (r == 0) y = 32'd0;
      if (r == 1) y = x;
      run_op("rand", o, x, y, 5'($urandom_range(0, 31)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
